alu32_seq_ctrl: RTL and testbench

Sequencer that runs 32-bit operations (add, sub, and, or, unsigned compare) on the existing 16-bit ALU. It splits each request into a low-half pass and a high-half pass, chains the carry between them, and merges the result and flags. It sits between the datapath control/issue logic, which uses a valid/ready request and response, and the single shared 16-bit ALU instance.

---
 rtl/alu32_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_alu32_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu32_seq_ctrl.sv
`timescale 1ns/1ps
// Purpose : 32-bit add/sub/and/or/unsigned-compare sequenced as two passes over the shared 16-bit ALU.
// Latency : rsp_valid rises 2*ALU_LAT cycles after the accept edge (illegal opcode: 1 cycle).
// Backpres: req_ready is high only in IDLE; the response is held stable in DONE until rsp_ready.
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   req_valid/req_ready/req_op/req_a/req_b   request handshake, opcode (0 add,1 sub,2 and,3 or,4 cmp), operands
//   rsp_valid/rsp_ready            response handshake
//   rsp_result/cout/zero/lt/eq/gt/err/ovf    merged 32-bit result and flags
//   alu_x/alu_y/alu_cin/alu_opcod  drive to the shared 16-bit ALU
//   alu_out/alu_cout/alu_lt/alu_eq/alu_gt    results back from the ALU
//
// Optional feature macro: ALU32_SEQ_OVF_EN builds the signed-overflow flag for add/sub;
// without it rsp_ovf is tied 0.
module alu32_seq_ctrl #(
  parameter int ALU_LAT = 1  // cycles ALU inputs are held per half, legal 1..4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_cout,
  output logic        rsp_zero,
  output logic        rsp_lt,
  output logic        rsp_eq,
  output logic        rsp_gt,
  output logic        rsp_err,
  output logic        rsp_ovf,
  output logic [15:0] alu_x,
  output logic [15:0] alu_y,
  output logic        alu_cin,
  output logic [2:0]  alu_opcod,
  input  logic [15:0] alu_out,
  input  logic        alu_cout,
  input  logic        alu_lt,
  input  logic        alu_eq,
  input  logic        alu_gt
);

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_CMP  = 3'd4;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam logic [1:0] LAT_M1  = 2'(ALU_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      state_q;
  logic [1:0]  wait_q;
  logic [2:0]  op_q;
  logic [15:0] a_hi_q;
  logic [15:0] b_hi_q;
  logic [15:0] lo_res_q;
  logic        lo_lt_q, lo_eq_q, lo_gt_q;

  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_result_q;
  logic        rsp_cout_q, rsp_zero_q, rsp_lt_q, rsp_eq_q, rsp_gt_q, rsp_err_q;
  logic [15:0] alu_x_q, alu_y_q;
  logic        alu_cin_q;
  logic [2:0]  alu_opcod_q;

  // Low-pass ALU opcode for a freshly accepted request.
  function automatic logic [2:0] lo_opcod(input logic [2:0] op);
    case (op)
      OP_SUB, OP_CMP: lo_opcod = ALU_SUB;
      OP_AND:         lo_opcod = ALU_AND;
      OP_OR:          lo_opcod = ALU_OR;
      default:        lo_opcod = ALU_ADD;
    endcase
  endfunction

  logic        is_subcmp_d;
  logic        is_logic_d;
  logic        wait_last_d;
  logic [15:0] hi_y_d;
  logic [2:0]  hi_opcod_d;
  logic [31:0] res_d;
  logic        hi_lt_d, hi_eq_d, hi_gt_d;

  assign is_subcmp_d = (op_q == OP_SUB) || (op_q == OP_CMP);
  assign is_logic_d  = (op_q == OP_AND) || (op_q == OP_OR);
  assign wait_last_d = (wait_q == LAT_M1);
  // The high half of a subtract is an add of ~B with the chained carry, since the ALU's
  // own subtract forces cin=1 and would lose the borrow from the low half.
  assign hi_y_d      = is_subcmp_d ? ~b_hi_q : b_hi_q;
  assign hi_opcod_d  = is_logic_d ? alu_opcod_q : ALU_ADD;
  assign res_d       = {alu_out, lo_res_q};
  // The ALU comparator sees ~B in the high pass of sub/cmp, so the upper-half compare is local.
  assign hi_lt_d     = a_hi_q <  b_hi_q;
  assign hi_eq_d     = a_hi_q == b_hi_q;
  assign hi_gt_d     = a_hi_q >  b_hi_q;

`ifdef ALU32_SEQ_OVF_EN
  logic rsp_ovf_q;
  logic b_eff31_d;
  logic ovf_d;
  assign b_eff31_d = (op_q == OP_ADD) ? b_hi_q[15] : ~b_hi_q[15];
  assign ovf_d     = ((op_q == OP_ADD) || (op_q == OP_SUB)) &&
                     (a_hi_q[15] == b_eff31_d) && (alu_out[15] != a_hi_q[15]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wait_q       <= 2'd0;
      op_q         <= 3'd0;
      a_hi_q       <= 16'd0;
      b_hi_q       <= 16'd0;
      lo_res_q     <= 16'd0;
      lo_lt_q      <= 1'b0;
      lo_eq_q      <= 1'b0;
      lo_gt_q      <= 1'b0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= 32'd0;
      rsp_cout_q   <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_lt_q     <= 1'b0;
      rsp_eq_q     <= 1'b0;
      rsp_gt_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
`ifdef ALU32_SEQ_OVF_EN
      rsp_ovf_q    <= 1'b0;
`endif
      alu_x_q      <= 16'd0;
      alu_y_q      <= 16'd0;
      alu_cin_q    <= 1'b0;
      alu_opcod_q  <= 3'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            a_hi_q      <= req_a[31:16];
            b_hi_q      <= req_b[31:16];
            wait_q      <= 2'd0;
            req_ready_q <= 1'b0;
            if (req_op > OP_CMP) begin
              state_q      <= S_DONE;
              rsp_result_q <= 32'd0;
              rsp_cout_q   <= 1'b0;
              rsp_zero_q   <= 1'b0;
              rsp_lt_q     <= 1'b0;
              rsp_eq_q     <= 1'b0;
              rsp_gt_q     <= 1'b0;
              rsp_err_q    <= 1'b1;
`ifdef ALU32_SEQ_OVF_EN
              rsp_ovf_q    <= 1'b0;
`endif
            end else begin
              state_q     <= S_LO;
              alu_x_q     <= req_a[15:0];
              alu_y_q     <= req_b[15:0];
              alu_cin_q   <= 1'b0;
              alu_opcod_q <= lo_opcod(req_op);
            end
          end
        end
        S_LO: begin
          if (wait_last_d) begin
            lo_res_q    <= alu_out;
            lo_lt_q     <= alu_lt;
            lo_eq_q     <= alu_eq;
            lo_gt_q     <= alu_gt;
            alu_x_q     <= a_hi_q;
            alu_y_q     <= hi_y_d;
            alu_cin_q   <= alu_cout;  // low-half carry chained straight into the high pass
            alu_opcod_q <= hi_opcod_d;
            wait_q      <= 2'd0;
            state_q     <= S_HI;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        S_HI: begin
          if (wait_last_d) begin
            rsp_result_q <= res_d;
            rsp_cout_q   <= alu_cout;
            rsp_zero_q   <= (res_d == 32'd0);
            rsp_err_q    <= 1'b0;
            if (hi_eq_d) begin
              rsp_lt_q <= lo_lt_q;
              rsp_eq_q <= lo_eq_q;
              rsp_gt_q <= lo_gt_q;
            end else begin
              rsp_lt_q <= hi_lt_d;
              rsp_eq_q <= 1'b0;
              rsp_gt_q <= hi_gt_d;
            end
`ifdef ALU32_SEQ_OVF_EN
            rsp_ovf_q    <= ovf_d;
`endif
            rsp_valid_q  <= 1'b1;
            wait_q       <= 2'd0;
            state_q      <= S_DONE;
          end else begin
            wait_q <= wait_q + 2'd1;
          end
        end
        S_DONE: begin
          // An illegal opcode enters DONE with rsp_valid low and raises it one cycle later.
          if (!rsp_valid_q) begin
            rsp_valid_q <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_cout   = rsp_cout_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_lt     = rsp_lt_q;
  assign rsp_eq     = rsp_eq_q;
  assign rsp_gt     = rsp_gt_q;
  assign rsp_err    = rsp_err_q;
`ifdef ALU32_SEQ_OVF_EN
  assign rsp_ovf    = rsp_ovf_q;
`else
  assign rsp_ovf    = 1'b0;
`endif
  assign alu_x      = alu_x_q;
  assign alu_y      = alu_y_q;
  assign alu_cin    = alu_cin_q;
  assign alu_opcod  = alu_opcod_q;

endmodule

// File: tb/tb_alu32_seq_ctrl.sv
`timescale 1ns/1ps
// Purpose : exercises alu32_seq_ctrl at ALU_LAT=1 and ALU_LAT=3 against a 32-bit arithmetic reference.
// Latency : checks 2*ALU_LAT response latency (1 for illegal opcodes) and handshake timing.
// Backpres: holds rsp_ready low for random/fixed stretches and checks response stability.
module tb_alu32_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [2:0]  req_op     [2];
  logic [31:0] req_a      [2];
  logic [31:0] req_b      [2];
  logic        rsp_valid  [2];
  logic        rsp_ready  [2];
  logic [31:0] rsp_result [2];
  logic        rsp_cout   [2];
  logic        rsp_zero   [2];
  logic        rsp_lt     [2];
  logic        rsp_eq     [2];
  logic        rsp_gt     [2];
  logic        rsp_err    [2];
  logic        rsp_ovf    [2];
  logic [15:0] alu_x      [2];
  logic [15:0] alu_y      [2];
  logic        alu_cin    [2];
  logic [2:0]  alu_opcod  [2];
  logic [19:0] alu_bus    [2];

  int errors = 0;
  int checks = 0;

  // 16-bit ALU: {out, cout, lt, eq, gt}. Subtract forces carry-in to 1.
  function automatic logic [19:0] alu16(input logic [2:0] op, input logic [15:0] x,
                                        input logic [15:0] y, input logic cin);
    logic [16:0] s;
    case (op)
      3'd0:    s = {1'b0, x} + {1'b0, y} + {16'd0, cin};
      3'd1:    s = {1'b0, x} + {1'b0, ~y} + 17'd1;
      3'd2:    s = {1'b0, x & y};
      3'd3:    s = {1'b0, x | y};
      default: s = 17'd0;
    endcase
    return {s[15:0], s[16], x < y, x == y, x > y};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_alu
    assign alu_bus[g] = alu16(alu_opcod[g], alu_x[g], alu_y[g], alu_cin[g]);
  end

  alu32_seq_ctrl #(.ALU_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_result(rsp_result[0]),
    .rsp_cout(rsp_cout[0]), .rsp_zero(rsp_zero[0]), .rsp_lt(rsp_lt[0]), .rsp_eq(rsp_eq[0]),
    .rsp_gt(rsp_gt[0]), .rsp_err(rsp_err[0]), .rsp_ovf(rsp_ovf[0]),
    .alu_x(alu_x[0]), .alu_y(alu_y[0]), .alu_cin(alu_cin[0]), .alu_opcod(alu_opcod[0]),
    .alu_out(alu_bus[0][19:4]), .alu_cout(alu_bus[0][3]), .alu_lt(alu_bus[0][2]),
    .alu_eq(alu_bus[0][1]), .alu_gt(alu_bus[0][0])
  );

  alu32_seq_ctrl #(.ALU_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_result(rsp_result[1]),
    .rsp_cout(rsp_cout[1]), .rsp_zero(rsp_zero[1]), .rsp_lt(rsp_lt[1]), .rsp_eq(rsp_eq[1]),
    .rsp_gt(rsp_gt[1]), .rsp_err(rsp_err[1]), .rsp_ovf(rsp_ovf[1]),
    .alu_x(alu_x[1]), .alu_y(alu_y[1]), .alu_cin(alu_cin[1]), .alu_opcod(alu_opcod[1]),
    .alu_out(alu_bus[1][19:4]), .alu_cout(alu_bus[1][3]), .alu_lt(alu_bus[1][2]),
    .alu_eq(alu_bus[1][1]), .alu_gt(alu_bus[1][0])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  typedef struct packed {
    logic [31:0] res;
    logic        cout, zero, lt, eq, gt, err, ovf, chk_cout;
  } exp_t;

  // Reference: plain 32-bit arithmetic on the whole operands.
  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
`ifdef ALU32_SEQ_OVF_EN
    longint sum;
`endif
    e = '0;
    if (op > 3'd4) begin
      e.err = 1'b1;
      e.chk_cout = 1'b1;
      return e;
    end
    case (op)
      3'd0: begin e.res = a + b; e.cout = ({1'b0, a} + {1'b0, b}) > 33'h0_FFFF_FFFF; e.chk_cout = 1'b1; end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      default: begin e.res = a - b; e.cout = (a >= b); e.chk_cout = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    e.lt = a < b;
    e.eq = a == b;
    e.gt = a > b;
`ifdef ALU32_SEQ_OVF_EN
    if (op == 3'd0 || op == 3'd1) begin
      sum = (op == 3'd0) ? longint'($signed(a)) + longint'($signed(b))
                         : longint'($signed(a)) - longint'($signed(b));
      e.ovf = (sum != longint'($signed(e.res)));
    end
`endif
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_rsp(input int k, input exp_t e);
    check("result", rsp_result[k], e.res);
    check("zero",   rsp_zero[k],   e.zero);
    check("lt",     rsp_lt[k],     e.lt);
    check("eq",     rsp_eq[k],     e.eq);
    check("gt",     rsp_gt[k],     e.gt);
    check("err",    rsp_err[k],    e.err);
    check("ovf",    rsp_ovf[k],    e.ovf);
    if (e.chk_cout) check("cout", rsp_cout[k], e.cout);
  endtask

  task automatic check_cleared(input int k);
    check("rst_rsp_valid", rsp_valid[k], 0);
    check("rst_result",    rsp_result[k], 0);
    check("rst_flags", {rsp_cout[k], rsp_zero[k], rsp_lt[k], rsp_eq[k], rsp_gt[k], rsp_err[k], rsp_ovf[k]}, 0);
    check("rst_alu_in", {alu_x[k], alu_y[k]}, 0);
    check("rst_alu_ctl", {alu_cin[k], alu_opcod[k]}, 0);
    check("rst_req_ready", req_ready[k], 1);
  endtask

  task automatic do_op(input int k, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int hold);
    exp_t e;
    int lat;
    int exp_lat;
    e = ref_model(op, a, b);
    exp_lat = (op > 3'd4) ? 1 : 2 * lat_of(k);
    @(negedge clk);
    check("req_ready_idle", req_ready[k], 1);
    req_valid[k] = 1'b1;
    req_op[k] = op;
    req_a[k] = a;
    req_b[k] = b;
    @(posedge clk); #1;
    // Scramble inputs while busy; a stray req_valid must be ignored.
    req_valid[k] = 1'($urandom_range(0, 1));
    req_op[k] = 3'($urandom);
    req_a[k] = $urandom;
    req_b[k] = $urandom;
    check("req_ready_busy", req_ready[k], 0);
    lat = 0;
    while (rsp_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_lat);
    if (rsp_valid[k] === 1'b1) begin
      check_rsp(k, e);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      check("hold_valid", rsp_valid[k], 1);
      check("hold_result", rsp_result[k], e.res);
      check("hold_req_ready", req_ready[k], 0);
      @(negedge clk);
      req_valid[k] = 1'b0;
      rsp_ready[k] = 1'b1;
      @(posedge clk); #1;
      rsp_ready[k] = 1'b0;
      check("valid_drop", rsp_valid[k], 0);
      check("idle_req_ready", req_ready[k], 1);
      check("data_after_drop", rsp_result[k], e.res);
    end else begin
      @(negedge clk);
      req_valid[k] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    int seen;
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; req_op[k] = 3'd0; req_a[k] = 32'd0; req_b[k] = 32'd0;
      rsp_ready[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_cleared(0);
    check_cleared(1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases at ALU_LAT=1.
    do_op(0, 3'd0, 32'h0000FFFF, 32'h00000001, 0);
    do_op(0, 3'd1, 32'h00010000, 32'h00000001, 1);
    do_op(0, 3'd1, 32'h00000000, 32'h00000001, 0);
    do_op(0, 3'd4, 32'h00010000, 32'h0001FFFF, 0);
    do_op(0, 3'd4, 32'h12345678, 32'h12345678, 0);
    do_op(0, 3'd2, 32'hF0F0FF00, 32'hFF00F0F0, 0);
    do_op(0, 3'd3, 32'hF0F0FF00, 32'hFF00F0F0, 0);
    do_op(0, 3'd6, 32'hDEADBEEF, 32'h01234567, 2);
    do_op(0, 3'd0, 32'h7FFFFFFF, 32'h00000001, 5);
    do_op(0, 3'd1, 32'h80000000, 32'h00000001, 0);
    do_op(0, 3'd4, 32'hFFFF0000, 32'h0000FFFF, 0);

    // Randomized, with bias toward equal upper halves and equal operands.
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = {a[31:16], 16'($urandom)};
        1:       b = a;
        default: b = $urandom;
      endcase
      do_op(0, 3'($urandom_range(0, 7)), a, b, $urandom_range(0, 2));
    end

    // ALU_LAT=3 instance.
    do_op(1, 3'd0, 32'h0000FFFF, 32'h00000001, 0);
    do_op(1, 3'd1, 32'h00000000, 32'h00000001, 1);
    do_op(1, 3'd4, 32'h12345678, 32'h12345678, 0);
    do_op(1, 3'd7, 32'h00000005, 32'h00000003, 0);
    for (int i = 0; i < 10; i++) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? {a[31:16], 16'($urandom)} : $urandom;
      do_op(1, 3'($urandom_range(0, 7)), a, b, $urandom_range(0, 1));
    end

    // Reset in the middle of the high pass: op is lost, outputs cleared, no response.
    do_op(0, 3'd0, 32'h11112222, 32'h33334444, 0);
    @(negedge clk);
    req_valid[0] = 1'b1; req_op[0] = 3'd0; req_a[0] = 32'h12345678; req_b[0] = 32'h11111111;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check_cleared(0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) seen++;
    end
    check("no_rsp_after_reset", seen, 0);
    do_op(0, 3'd1, 32'h00000005, 32'h00000007, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
